// File: rtl/fir_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_input_loader
// Purpose  : Front end of the FIR filter. It decodes a byte-wide command
//            stream that arrives on an asynchronous strobe. The stream
//            produces coefficient-bank writes and a valid/ready sample stream
//            toward the filter core.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            ena          - design enable; low freezes command processing
//            in_data      - command/data byte from the pins
//            in_strobe    - byte strobe, asynchronous to clk
//            core_ready   - core can accept a sample
//            sample_out   - sample to the core
//            sample_valid - sample_out is valid
//            coef_bus     - coefficient bank, tap k at [k*COEF_W +: COEF_W]
//            coef_update  - one-cycle pulse after any bank change
//            busy         - FSM is not in IDLE
//            overrun      - sticky flag for a dropped byte
// Revision : 1.0 - initial release
// ============================================================================
module fir_input_loader #(
    parameter int TAPS   = 4,   // power of 2, at most 4 (index lives in cmd[1:0])
    parameter int COEF_W = 8,
    parameter int DATA_W = 8    // pin byte width; opcode decode needs >= 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_strobe,
    input  logic                     core_ready,
    output logic [DATA_W-1:0]        sample_out,
    output logic                     sample_valid,
    output logic [TAPS*COEF_W-1:0]   coef_bus,
    output logic                     coef_update,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_WAIT_COEF   = 2'd1;
    localparam logic [1:0] S_WAIT_SAMPLE = 2'd2;
    localparam logic [1:0] S_HOLD        = 2'd3;

    localparam logic [1:0] OP_LOAD_COEF  = 2'b01;
    localparam logic [1:0] OP_SAMPLE     = 2'b10;
    localparam logic [1:0] OP_CLEAR      = 2'b11;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_s1;
    logic                   r_s2;
    logic                   r_s3;
    logic [IDX_W-1:0]       r_idx;
    logic [TAPS*COEF_W-1:0] r_coef_bus;
    logic                   r_coef_update;
    logic [DATA_W-1:0]      r_sample_out;
    logic                   r_sample_valid;
    logic                   r_overrun;

    logic                   w_take;
    logic [1:0]             w_op;
    logic                   w_handshake;
    logic                   w_busy;
    logic                   w_clear;
    logic                   w_load_idx;
    logic                   w_coef_wr;
    logic                   w_smp_wr;
    logic                   w_drop;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    // These flops run regardless of ena. A strobe that was already high when
    // ena rises has therefore been consumed and does not produce a late edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= in_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // The host keeps in_data stable well past the accepting edge. The byte
    // can therefore be taken straight from the pins without its own capture
    // register.
    assign w_take      = r_s2 & ~r_s3 & ena;
    assign w_op        = in_data[7:6];
    assign w_handshake = ena & r_sample_valid & core_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    if (w_op == OP_LOAD_COEF) begin
                        w_state_next = S_WAIT_COEF;
                    end else if (w_op == OP_SAMPLE) begin
                        w_state_next = S_WAIT_SAMPLE;
                    end
                end
            end
            S_WAIT_COEF: begin
                if (w_take) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_SAMPLE: begin
                if (w_take) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                // A byte that arrives with the handshake is dropped. The
                // completed transfer still returns the FSM to IDLE.
                if (w_handshake) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_clear    = 1'b0;
        w_load_idx = 1'b0;
        w_coef_wr  = 1'b0;
        w_smp_wr   = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear    = w_take & (w_op == OP_CLEAR);
                w_load_idx = w_take & (w_op == OP_LOAD_COEF);
            end
            S_WAIT_COEF:   w_coef_wr = w_take;
            S_WAIT_SAMPLE: w_smp_wr  = w_take;
            S_HOLD:        w_drop    = w_take;
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_coef_bus     <= '0;
            r_coef_update  <= 1'b0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            // CLEAR pulses coef_update even when the bank is already zero.
            r_coef_update <= w_clear | w_coef_wr;

            if (w_load_idx) begin
                r_idx <= in_data[IDX_W-1:0];
            end

            for (int k = 0; k < TAPS; k++) begin
                if (w_clear) begin
                    r_coef_bus[k*COEF_W +: COEF_W] <= '0;
                end else if (w_coef_wr && (r_idx == IDX_W'(k))) begin
                    r_coef_bus[k*COEF_W +: COEF_W] <= COEF_W'(in_data);
                end
            end

            if (w_clear) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (w_smp_wr) begin
                r_sample_out   <= in_data;
                r_sample_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && w_handshake) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign coef_bus     = r_coef_bus;
    assign coef_update  = r_coef_update;
    assign busy         = w_busy;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_input_loader
// Purpose  : Self-checking bench for fir_input_loader. It drives directed and
//            random command bytes. Results are compared against a
//            transaction-level model of the command protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_input_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  in_data;
    logic        in_strobe;
    logic        core_ready;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic [31:0] coef_bus;
    logic        coef_update;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    fir_input_loader #(.TAPS(4), .COEF_W(8), .DATA_W(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .in_data      (in_data),
        .in_strobe    (in_strobe),
        .core_ready   (core_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .coef_bus     (coef_bus),
        .coef_update  (coef_update),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event counters, sampled with the values the DUT sees at each edge.
    int n_upd  = 0;
    int n_xfer = 0;
    always @(posedge clk) begin
        if (coef_update === 1'b1) n_upd++;
        if (rst_n && ena && sample_valid === 1'b1 && core_ready) n_xfer++;
    end

    // ---------------- Reference model ----------------
    // m_mode: 0 idle, 1 awaiting coefficient, 2 awaiting sample, 3 sample pending
    logic [7:0] m_bank [4];
    logic [7:0] m_smp;
    bit         m_valid;
    bit         m_ovr;
    int         m_mode;
    int         m_idx;
    int         m_upd;
    int         m_xfer;

    function automatic logic [31:0] m_bus();
        return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
        m_smp   = 8'h00;
        m_valid = 0;
        m_ovr   = 0;
        m_mode  = 0;
        m_idx   = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        case (m_mode)
            0: begin
                case (b[7:6])
                    2'b01: begin m_mode = 1; m_idx = int'(b[1:0]); end
                    2'b10: m_mode = 2;
                    2'b11: begin
                        for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
                        m_ovr = 0;
                        m_upd++;
                    end
                    default: ;
                endcase
            end
            1: begin m_bank[m_idx] = b; m_upd++; m_mode = 0; end
            2: begin m_smp = b; m_valid = 1; m_mode = 3; end
            default: m_ovr = 1;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".coef_bus"},     64'(coef_bus),     64'(m_bus()));
        check({tag, ".sample_out"},   64'(sample_out),   64'(m_smp));
        check({tag, ".sample_valid"}, 64'(sample_valid), 64'(m_valid));
        check({tag, ".busy"},         64'(busy),         64'(m_mode != 0));
        check({tag, ".overrun"},      64'(overrun),      64'(m_ovr));
        check({tag, ".upd_pulses"},   64'(n_upd),        64'(m_upd));
        check({tag, ".transfers"},    64'(n_xfer),       64'(m_xfer));
    endtask

    // ---------------- Stimulus helpers ----------------
    // Strobe high for 4 clk, then low for 4 clk. Data stays stable throughout.
    // The rising edge lands at a random point inside the low clock phase.
    task automatic send(input logic [7:0] b, input string tag);
        @(negedge clk);
        #($urandom_range(0, 4));
        in_data   = b;
        in_strobe = 1'b1;
        repeat (4) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
        if (ena) m_byte(b);
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        core_ready = 1'b1;
        repeat (2) @(negedge clk);
        core_ready = 1'b0;
        if (m_mode == 3) begin
            m_mode  = 0;
            m_valid = 0;
            m_xfer++;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        in_data    = 8'h00;
        in_strobe  = 1'b0;
        core_ready = 1'b0;
        m_upd      = 0;
        m_xfer     = 0;
        m_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Coefficient write into tap 2
        send(8'h42, "load2_cmd");
        send(8'hA5, "load2_data");
        check("load2_bus", 64'(coef_bus), 64'h0000_0000_00A5_0000);

        // Sample with a stalled core, then the overrun case
        send(8'h80, "smp_cmd");
        send(8'h7F, "smp_data");
        repeat (5) @(negedge clk);
        check("smp_stall_valid", 64'(sample_valid), 64'h1);
        check("smp_stall_xfer",  64'(n_xfer),       64'(m_xfer));
        send(8'h33, "hold_overrun");
        drain("smp_drain");
        check("smp_value", 64'(sample_out), 64'h7F);
        send(8'h05, "nop_keeps_ovr");
        send(8'hC0, "clear");

        // Fill every tap, then NOP
        send(8'h40, "t0c"); send(8'h11, "t0d");
        send(8'h41, "t1c"); send(8'h22, "t1d");
        send(8'h42, "t2c"); send(8'h33, "t2d");
        send(8'h43, "t3c"); send(8'h44, "t3d");
        check("all_taps", 64'(coef_bus), 64'h44332211);
        send(8'h00, "nop");
        drain("ready_idle");

        // Asynchronous reset in the middle of a coefficient command
        send(8'h41, "pre_rst_cmd");
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("async_rst_bus",  64'(coef_bus), 64'h0);
        check("async_rst_busy", 64'(busy),     64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h22, "post_rst_nop");

        // Disabled: bytes discarded
        ena = 1'b0;
        send(8'h41, "ena0_cmd");
        send(8'h99, "ena0_data");
        // Strobe already high when ena returns must not be taken
        @(negedge clk);
        in_data   = 8'h80;
        in_strobe = 1'b1;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
        check_all("ena_rise_strobe_high");

        // Randomized command stream
        for (int it = 0; it < 150; it++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 9));
            b = 8'($urandom);
            if (r < 2) begin
                drain("rnd_drain");
            end else if (r == 2) begin
                send(8'hC0 | (b & 8'h3F), "rnd_clear");
            end else begin
                send(b, "rnd_byte");
            end
        end
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
